// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the alu_sched block: FSM states, ALU
// opcode values and the bit positions of the packed flag vector.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  // Flag vector layout is {Zero, Negative, Carry, Overflow}
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu8.sv
// 8-bit ALU shared by the scheduler. ADD/SUB/AND/OR; unused opcodes give 0.
// Carry on SUB is the carry-out of a + ~b + 1 (1 means no borrow).
module alu8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] ALUControl,
  output logic [7:0] Result,
  output logic       Zero,
  output logic       Negative,
  output logic       Carry,
  output logic       Overflow
);

  logic [7:0] b_eff;
  logic [8:0] sum;

  // Shared adder: SUB reuses it with inverted B and a carry-in of one
  always_comb begin
    b_eff    = ALUControl[0] ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {8'd0, ALUControl[0]};
    Result   = 8'd0;
    Carry    = 1'b0;
    Overflow = 1'b0;
    case (ALUControl)
      3'b000, 3'b001: begin
        Result   = sum[7:0];
        Carry    = sum[8];
        Overflow = (a[7] == b_eff[7]) && (sum[7] != a[7]);
      end
      3'b010:  Result = a & b;
      3'b011:  Result = a | b;
      default: Result = 8'd0;
    endcase
    Zero     = (Result == 8'd0);
    Negative = Result[7];
  end

endmodule

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin arbiter. last_grant resets to requester 1 so that
// requester 0 wins the first contention. It only moves on 'advance'.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q;
  logic last_d;

  // One-hot grant: a lone requester wins, a tie goes to the other side
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    last_d = advance ? grant[1] : last_q;
  end

  // Remember who was served last
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one alu8 between two requesters with a
// single op in flight: IDLE (arbitrate) -> EXEC (ALU) -> RESP (hold result).
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising edge; ready never depends on the requester's own data.
// Optional: define ALU_SCHED_STATS_EN for saturating per-requester counters.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              busy,
  output logic [CNT_W-1:0]  stat_cnt0,
  output logic [CNT_W-1:0]  stat_cnt1
);

  state_e            state_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [2:0]        op_q;
  logic              id_q;
  logic              rsp_valid_q, rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic [3:0]        rsp_flags_q;

  logic [1:0]        grant;
  logic              accept;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_flags;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1_valid, req0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  alu8 u_alu (
    .a          (a_q),
    .b          (b_q),
    .ALUControl (op_q),
    .Result     (alu_result),
    .Zero       (alu_flags[FLAG_Z]),
    .Negative   (alu_flags[FLAG_N]),
    .Carry      (alu_flags[FLAG_C]),
    .Overflow   (alu_flags[FLAG_V])
  );

  // Requests are only taken while idle; grant is already one-hot or zero
  always_comb begin
    req0_ready = (state_q == IDLE) && grant[0];
    req1_ready = (state_q == IDLE) && grant[1];
    accept     = req0_ready || req1_ready;
  end

  // Scheduler FSM: latch granted op, capture ALU output, hold response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 3'd0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= grant[1] ? req1_a  : req0_a;
            b_q     <= grant[1] ? req1_b  : req0_b;
            op_q    <= grant[1] ? req1_op : req0_op;
            id_q    <= grant[1];
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_flags_q  <= alu_flags;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = (state_q != IDLE);

`ifdef ALU_SCHED_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  logic             rsp_hs;

  assign rsp_hs = rsp_valid_q && rsp_ready;

  // Count completed responses per requester, sticking at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (rsp_hs) begin
      if (!rsp_id_q && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_ONE;
      if (rsp_id_q  && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_ONE;
    end
  end

  assign stat_cnt0 = cnt0_q;
  assign stat_cnt1 = cnt1_q;
`else
  assign stat_cnt0 = '0;
  assign stat_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Testbench for alu_sched: cycle-stepped driver, a transaction-level model
// of arbitration/latency, and an expected-response queue for ALU results.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int DW = 8;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]    req0_op, req1_op;
  logic          rsp_valid, rsp_ready, rsp_id, busy;
  logic [DW-1:0] rsp_result;
  logic [3:0]    rsp_flags;
  logic [CW-1:0] stat_cnt0, stat_cnt1;

  alu_sched #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy),
    .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0] exp_q[$];     // {id, flags, result} of the op in flight
  int          grant_log[$];
  int          rsp_log[$];
  int          n_rsp = 0;

  // Requester-side pending ops
  bit         pend[2];
  logic [7:0] pa[2], pb[2];
  logic [2:0] pop[2];

  // Stimulus controls, applied only inside tick()
  bit rst_val  = 1'b0;
  bit rr_val   = 1'b1;
  bit rr_rand  = 1'b0;
  bit rand_src = 1'b0;
  bit refill[2];
  bit chk_en   = 1'b0;

  // Transaction-level model
  bit m_exec      = 1'b0;   // op accepted, result not yet presented
  bit m_rsp_valid = 1'b0;   // result presented, waiting for consumer
  bit m_last      = 1'b1;
  int m_cnt[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU from plain integer arithmetic
  function automatic logic [12:0] ref_alu(input int id, input logic [7:0] a,
                                          input logic [7:0] b, input logic [2:0] op);
    int ua, ub, sa, sb, r, sr;
    bit c, v;
    logic [7:0] res;
    logic [3:0] fl;
    ua = int'(a); ub = int'(b);
    sa = a[7] ? ua - 256 : ua;
    sb = b[7] ? ub - 256 : ub;
    c = 1'b0; v = 1'b0; r = 0;
    case (op)
      OP_ADD: begin r = ua + ub; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
      OP_SUB: begin r = ua - ub; c = (ua >= ub); sr = sa - sb; v = (sr > 127) || (sr < -128); end
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      default: r = 0;
    endcase
    res = r[7:0];
    fl = 4'd0;
    fl[FLAG_Z] = (res == 8'd0);
    fl[FLAG_N] = res[7];
    fl[FLAG_C] = c;
    fl[FLAG_V] = v;
    return {id[0], fl, res};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic new_op(input int i);
    pend[i] = 1'b1;
    pa[i]   = 8'($urandom_range(0, 255));
    pb[i]   = 8'($urandom_range(0, 255));
    pop[i]  = 3'($urandom_range(0, 7));
  endtask

  task automatic put(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    pend[i] = 1'b1; pa[i] = a; pb[i] = b; pop[i] = op;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check ready,
  // then advance the model to what the next rising edge should produce.
  task automatic tick();
    int win;
    bit idle;
    int id;
    @(negedge clk);
    if (chk_en) begin
      check("rsp_valid", rsp_valid, m_rsp_valid);
      check("busy", busy, m_exec || m_rsp_valid);
      if (m_rsp_valid && exp_q.size() > 0)
        check("rsp_data", {rsp_id, rsp_flags, rsp_result}, exp_q[0]);
      check("stat_cnt0", stat_cnt0, m_cnt[0]);
      check("stat_cnt1", stat_cnt1, m_cnt[1]);
    end
    for (int i = 0; i < 2; i++) begin
      if (rand_src) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) new_op(i);
        else if (pend[i] && $urandom_range(0, 3) == 0) new_op(i);
      end else if (refill[i] && !pend[i]) begin
        new_op(i);
      end
    end
    if (rr_rand) rr_val = 1'($urandom_range(0, 1));
    rst_n      = rst_val;
    rsp_ready  = rr_val;
    req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0];
    req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1];
    #1;
    idle = !(m_exec || m_rsp_valid);
    win = -1;
    if (idle) begin
      if (pend[0] && pend[1]) win = m_last ? 0 : 1;
      else if (pend[0])       win = 0;
      else if (pend[1])       win = 1;
    end
    if (chk_en) begin
      check("req0_ready", req0_ready, win == 0);
      check("req1_ready", req1_ready, win == 1);
    end
    if (!rst_val) begin
      m_exec = 1'b0; m_rsp_valid = 1'b0; m_last = 1'b1;
      m_cnt[0] = 0; m_cnt[1] = 0;
      exp_q.delete();
    end else if (win >= 0) begin
      exp_q.push_back(ref_alu(win, pa[win], pb[win], pop[win]));
      grant_log.push_back(win);
      m_last = win[0];
      pend[win] = 1'b0;
      m_exec = 1'b1;
    end else if (m_exec) begin
      m_exec = 1'b0;
      m_rsp_valid = 1'b1;
    end else if (m_rsp_valid && rr_val) begin
      m_rsp_valid = 1'b0;
      id = int'(exp_q[0][12]);
      void'(exp_q.pop_front());
      rsp_log.push_back(int'(rsp_id));
      n_rsp++;
`ifdef ALU_SCHED_STATS_EN
      if (m_cnt[id] < (1 << CW) - 1) m_cnt[id]++;
`endif
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rand_src = 1'b0; rr_rand = 1'b0; rr_val = 1'b1;
    refill[0] = 1'b0; refill[1] = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    rst_val = 1'b0;
    run(2);
    rst_val = 1'b1;
    grant_log.delete(); rsp_log.delete(); n_rsp = 0;
  endtask

  // ---------------- test sequence ----------------
  logic [12:0] snap;
  int          budget;

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    pend[0] = 1'b0; pend[1] = 1'b0; refill[0] = 1'b0; refill[1] = 1'b0;
    m_cnt[0] = 0; m_cnt[1] = 0;

    // Reset: first cycle outputs are unknown, checks start after it
    rst_val = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst_val = 1'b1;
    tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_flags", rsp_flags, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", {req1_ready, req0_ready}, 0);

    // ADD via req0: 0x7F + 0x01
    put(0, 8'h7F, 8'h01, OP_ADD);
    tick();
    check("add_req0_ready", req0_ready, 1);
    tick();
    check("add_not_yet", rsp_valid, 0);
    tick();
    check("add_valid", rsp_valid, 1);
    check("add_id", rsp_id, 0);
    check("add_result", rsp_result, 8'h80);
    check("add_flags", rsp_flags, 4'b0101);
    tick();
    check("add_done", rsp_valid, 0);

    // SUB via req1: 5 - 5
    put(1, 8'h05, 8'h05, OP_SUB);
    run(3);
    check("sub_valid", rsp_valid, 1);
    check("sub_id", rsp_id, 1);
    check("sub_result", rsp_result, 8'h00);
    check("sub_z", rsp_flags[FLAG_Z], 1);
    check("sub_n", rsp_flags[FLAG_N], 0);
    tick();

    // Contention: both requesters always valid
    do_reset();
    refill[0] = 1'b1; refill[1] = 1'b1;
    budget = 0;
    while (n_rsp < 4 && budget < 60) begin tick(); budget++; end
    check("cont_timeout", n_rsp >= 4, 1);
    refill[0] = 1'b0; refill[1] = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    run(3);
    for (int k = 0; k < 4; k++) begin
      check("cont_grant", (grant_log.size() > k) ? grant_log[k] : -1, k % 2);
      check("cont_rsp_id", (rsp_log.size() > k) ? rsp_log[k] : -1, k % 2);
    end

    // Backpressure: consumer stalls for 5 cycles with req1 waiting
    do_reset();
    rr_val = 1'b0;
    put(0, 8'hC3, 8'h5A, OP_OR);
    budget = 0;
    do begin tick(); budget++; end while (!rsp_valid && budget < 10);
    check("bp_timeout", rsp_valid, 1);
    snap = {rsp_id, rsp_flags, rsp_result};
    put(1, 8'h10, 8'h20, OP_AND);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold", {rsp_id, rsp_flags, rsp_result}, snap);
      check("bp_busy", busy, 1);
      check("bp_no_ready", {req1_ready, req0_ready}, 0);
    end
    rr_val = 1'b1;
    tick();
    tick();
    check("bp_released", rsp_valid, 0);
    check("bp_next_grant", req1_ready, 1);
    run(4);

    // Reset the cycle after acceptance: the op must vanish
    put(0, 8'h01, 8'h02, OP_ADD);
    tick();
    check("rexec_accept", req0_ready, 1);
    rst_val = 1'b0;
    tick();
    rst_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rexec_no_rsp", rsp_valid, 0);
      check("rexec_idle", busy, 0);
    end
    check("rexec_cnt0", stat_cnt0, 0);

    // Counter saturation: 258 ops from requester 0
    do_reset();
    refill[0] = 1'b1;
    budget = 0;
    while (n_rsp < 258 && budget < 1200) begin tick(); budget++; end
    check("sat_timeout", n_rsp >= 258, 1);
    refill[0] = 1'b0; pend[0] = 1'b0;
    run(4);
`ifdef ALU_SCHED_STATS_EN
    check("sat_cnt0", stat_cnt0, 8'hFF);
`else
    check("sat_cnt0", stat_cnt0, 8'h00);
`endif
    check("sat_cnt1", stat_cnt1, 0);

    // Randomized traffic with random backpressure and unstable operands
    do_reset();
    rand_src = 1'b1; rr_rand = 1'b1;
    run(600);
    rand_src = 1'b0; rr_rand = 1'b0; rr_val = 1'b1;
    run(12);
    check("rand_drained", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
